risc8_intc: RTL and testbench

Interrupt controller that sits directly upstream of the risc8 core. It collects eight external interrupt sources plus one NMI source and drives the core's `int` and `nmi` inputs. It also serves as a memory-mapped slave on the core's bus, providing mask, mode, pending and in-service registers. During the core's interrupt-acknowledge cycle it supplies a vector byte on the read-data path and records the acknowledged source as in service.

---
 rtl/risc8_intc.sv | 142 ++++++++++++++
 tb/tb_risc8_intc.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/risc8_intc.sv
// risc8_intc: eight-source priority interrupt controller with NMI sync,
// bus-mapped PEND/MASK/MODE/ISR registers and iack vector supply.
module risc8_intc #(
   parameter logic [15:0] BASE_ADDR = 16'hFF00,
   parameter logic [7:0]  VEC_BASE  = 8'h40
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [7:0]  irq_in,
   input  logic        nmi_in,
   input  logic        cycle,
   input  logic        write,
   input  logic        iack,
   input  logic [15:0] address,
   input  logic [7:0]  wdata,
   output logic [7:0]  rdata,
   output logic        sel,
   output logic        ready,
   output logic        intr,
   output logic        nmi
);

   typedef enum logic {IDLE, RESP} state_t;

   state_t     state;
   logic [8:0] s1, s2, prev;
   logic [7:0] edge_pend, mask, mode, isr;
   logic [7:0] pend, req, blocked, elig;
   logic [7:0] rise, clr, win_oh, isr_lo;
   logic [7:0] mode_n, edge_n, isr_n, rd_val;
   logic [2:0] win;
   logic       any, hit, take, do_ack, do_wr;
   logic [1:0] a;

   assign nmi    = s2[8];
   assign a      = address[1:0];
   assign hit    = address[15:2] == BASE_ADDR[15:2];
   assign take   = (state == IDLE) && cycle && (iack || hit);
   assign do_ack = take && iack && any;
   assign do_wr  = take && !iack && write;
   assign rise   = s2[7:0] & ~prev[7:0];
   assign win_oh = 8'd1 << win;
   assign isr_lo = isr & (~isr + 8'd1);

   // Pending view, priority blocking by in-service bits, winner select
   always_comb begin
      pend = (mode & edge_pend) | (~mode & s2[7:0]);
      req = pend & mask;
      blocked[0] = isr[0];
      for (int i = 1; i < 8; i++)
         blocked[i] = blocked[i-1] | isr[i];
      elig = req & ~blocked;
      any = |elig;
      win = 3'd0;
      for (int i = 7; i >= 0; i--)
         if (elig[i]) win = 3'(i);
   end

   // Next-state of edge pending, mode and in-service from bus events
   always_comb begin
      clr = 8'h00;
      if (do_wr && a == 2'd0) clr = clr | wdata;
      if (do_ack) clr = clr | (win_oh & mode);
      mode_n = (do_wr && a == 2'd2) ? wdata : mode;
      edge_n = ((edge_pend & ~clr) | (rise & mode)) & mode_n;
      isr_n = isr;
      if (do_ack) isr_n = isr | win_oh;
      else if (do_wr && a == 2'd3) isr_n = isr & ~isr_lo;
   end

   // Register read mux
   always_comb begin
      rd_val = 8'h00;
      unique case (a)
         2'd0: rd_val = pend;
         2'd1: rd_val = mask;
         2'd2: rd_val = mode;
         2'd3: rd_val = isr;
      endcase
   end

   // Two-flop synchronizers plus edge-detect history
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s1 <= '0;
         s2 <= '0;
         prev <= '0;
      end else begin
         s1 <= {nmi_in, irq_in};
         s2 <= s1;
         prev <= s2;
      end
   end

   // Controller registers and registered interrupt request
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         edge_pend <= '0;
         mask <= '0;
         mode <= '0;
         isr <= '0;
         intr <= 1'b0;
      end else begin
         edge_pend <= edge_n;
         mode <= mode_n;
         isr <= isr_n;
         intr <= any;
         if (do_wr && a == 2'd1) mask <= wdata;
      end
   end

   // Bus FSM: one wait state, registered response outputs
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
         ready <= 1'b0;
         sel <= 1'b0;
         rdata <= 8'h00;
      end else begin
         unique case (state)
            IDLE: begin
               if (take) begin
                  state <= RESP;
                  ready <= 1'b1;
                  sel <= iack | ~write;
                  if (iack)
                     rdata <= any ? (VEC_BASE | {5'd0, win})
                                  : (VEC_BASE | 8'h08);
                  else if (!write)
                     rdata <= rd_val;
               end
            end
            RESP: begin
               state <= IDLE;
               ready <= 1'b0;
               sel <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_risc8_intc.sv
// tb_risc8_intc: directed plus random checks of risc8_intc against a
// sample-history reference model.
module tb_risc8_intc;

   logic        clk = 1'b0;
   logic        rst;
   logic [7:0]  irq_in;
   logic        nmi_in;
   logic        cycle, write, iack;
   logic [15:0] address;
   logic [7:0]  wdata;
   logic [7:0]  rdata;
   logic        sel, ready, intr, nmi;

   int total = 0;
   int bad = 0;

   risc8_intc dut (
      .clk(clk), .rst(rst), .irq_in(irq_in), .nmi_in(nmi_in),
      .cycle(cycle), .write(write), .iack(iack), .address(address),
      .wdata(wdata), .rdata(rdata), .sel(sel), .ready(ready),
      .intr(intr), .nmi(nmi)
   );

   always #5 clk = ~clk;

   // reference model state: raw samples of {nmi,irq} at recent edges
   logic [8:0] smp0, smp1, smp2;
   logic [7:0] m_ep, m_mask, m_mode, m_isr, m_rd;
   logic       m_busy, m_ready, m_sel, m_int;

   task automatic model_reset();
      smp0 = 0; smp1 = 0; smp2 = 0;
      m_ep = 0; m_mask = 0; m_mode = 0; m_isr = 0; m_rd = 0;
      m_busy = 0; m_ready = 0; m_sel = 0; m_int = 0;
   endtask

   task automatic model_step();
      logic [7:0] s2v, pv, pendv, clr, nmode, nisr, nmask;
      logic [7:0] nep, nrd;
      logic nready, nsel, nbusy, blk, anyel;
      int win;
      s2v = smp1[7:0];
      pv = smp2[7:0];
      win = -1;
      blk = 0;
      for (int i = 0; i < 8; i++) begin
         pendv[i] = m_mode[i] ? m_ep[i] : s2v[i];
         blk = blk | m_isr[i];
         if (win < 0 && pendv[i] && m_mask[i] && !blk) win = i;
      end
      anyel = (win >= 0);
      clr = 0; nmode = m_mode; nisr = m_isr; nmask = m_mask;
      nrd = m_rd; nready = 0; nsel = 0; nbusy = 0;
      if (!m_busy && cycle && (iack || address[15:2] == 14'h3FC0)) begin
         nbusy = 1; nready = 1;
         if (iack) begin
            nsel = 1;
            if (anyel) begin
               nrd = 8'h40 + 8'(win);
               nisr[win] = 1'b1;
               if (m_mode[win]) clr[win] = 1'b1;
            end else nrd = 8'h48;
         end else if (write) begin
            case (address[1:0])
               2'd0: clr = wdata;
               2'd1: nmask = wdata;
               2'd2: nmode = wdata;
               default: begin
                  for (int i = 0; i < 8; i++)
                     if (m_isr[i]) begin
                        nisr[i] = 1'b0;
                        break;
                     end
               end
            endcase
         end else begin
            nsel = 1;
            case (address[1:0])
               2'd0: nrd = pendv;
               2'd1: nrd = m_mask;
               2'd2: nrd = m_mode;
               default: nrd = m_isr;
            endcase
         end
      end
      for (int i = 0; i < 8; i++) begin
         logic rise_i;
         rise_i = s2v[i] && !pv[i] && m_mode[i];
         nep[i] = ((m_ep[i] && !clr[i]) || rise_i) && nmode[i];
      end
      m_ep = nep; m_mode = nmode; m_mask = nmask; m_isr = nisr;
      m_rd = nrd; m_ready = nready; m_sel = nsel; m_busy = nbusy;
      m_int = anyel;
      smp2 = smp1; smp1 = smp0; smp0 = {nmi_in, irq_in};
   endtask

   task automatic check(input string name, input logic [7:0] act,
                        input logic [7:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
      end
   endtask

   initial forever begin
      @(posedge clk);
      if (rst) model_reset();
      else model_step();
   end

   initial forever begin
      @(negedge clk);
      check("ready", {7'd0, ready}, {7'd0, m_ready});
      check("sel", {7'd0, sel}, {7'd0, m_sel});
      check("int", {7'd0, intr}, {7'd0, m_int});
      check("nmi", {7'd0, nmi}, {7'd0, smp1[8]});
      check("rdata", rdata, m_rd);
   end

   task automatic cyc(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic bus(input logic w, input logic ia, input logic [1:0] a,
                      input logic [7:0] d, output logic [7:0] got);
      cycle = 1; write = w; iack = ia;
      address = {14'h3FC0, a}; wdata = d;
      cyc(1);
      cycle = 0; write = 0; iack = 0;
      @(negedge clk);
      got = rdata;
      cyc(1);
   endtask

   logic [7:0] got;

   initial begin
      rst = 1; irq_in = 0; nmi_in = 0;
      cycle = 0; write = 0; iack = 0; address = 0; wdata = 0;
      model_reset();
      cyc(3);
      rst = 0;
      cyc(1);

      for (int r = 0; r < 4; r++) begin
         bus(0, 0, 2'(r), 0, got);
         check("reset_reg", got, 8'h00);
      end
      check("reset_int", {7'd0, intr}, 8'h00);

      bus(1, 0, 2, 8'h08, got);
      bus(1, 0, 1, 8'h08, got);
      irq_in[3] = 1;
      cyc(1);
      irq_in[3] = 0;
      cyc(2);
      check("edge_int_e2", {7'd0, intr}, 8'h00);
      cyc(1);
      check("edge_int_e3", {7'd0, intr}, 8'h01);
      bus(0, 1, 0, 0, got);
      check("iack3", got, 8'h43);
      bus(0, 0, 3, 0, got);
      check("isr08", got, 8'h08);
      bus(0, 0, 0, 0, got);
      check("pend0", got, 8'h00);
      check("int_fall", {7'd0, intr}, 8'h00);

      bus(1, 0, 1, 8'h2A, got);
      irq_in[5] = 1;
      cyc(4);
      check("nest_blocked", {7'd0, intr}, 8'h00);
      irq_in[1] = 1;
      cyc(4);
      check("nest_int", {7'd0, intr}, 8'h01);
      bus(0, 1, 0, 0, got);
      check("iack1", got, 8'h41);
      bus(0, 0, 3, 0, got);
      check("isr0a", got, 8'h0A);
      irq_in = 0;
      cyc(3);
      bus(1, 0, 3, 8'h00, got);
      bus(0, 0, 3, 0, got);
      check("eoi1", got, 8'h08);
      bus(1, 0, 3, 8'h00, got);
      bus(0, 0, 3, 0, got);
      check("eoi2", got, 8'h00);

      bus(1, 0, 1, 8'h00, got);
      irq_in[0] = 1;
      cyc(4);
      check("lvl_masked", {7'd0, intr}, 8'h00);
      bus(1, 0, 1, 8'h01, got);
      check("lvl_int", {7'd0, intr}, 8'h01);
      irq_in[0] = 0;
      cyc(3);
      bus(0, 1, 0, 0, got);
      check("spurious", got, 8'h48);
      bus(0, 0, 3, 0, got);
      check("spur_isr", got, 8'h00);

      bus(1, 0, 2, 8'h04, got);
      bus(1, 0, 1, 8'h00, got);
      irq_in[2] = 1;
      cyc(1);
      irq_in[2] = 0;
      cyc(4);
      bus(0, 0, 0, 0, got);
      check("pend04", got, 8'h04);
      bus(1, 0, 0, 8'h04, got);
      bus(0, 0, 0, 0, got);
      check("w1c", got, 8'h00);
      irq_in[2] = 1;
      cyc(2);
      bus(1, 0, 0, 8'h04, got);
      bus(0, 0, 0, 0, got);
      check("w1c_set_wins", got, 8'h04);
      irq_in[2] = 0;
      cyc(3);

      cycle = 1; write = 1; iack = 0;
      address = 16'hFF01; wdata = 8'hFF;
      cyc(1);
      cycle = 0; write = 0;
      check("resp_ready", {7'd0, ready}, 8'h01);
      rst = 1;
      model_reset();
      #1;
      check("rst_ready", {7'd0, ready}, 8'h00);
      cyc(2);
      rst = 0;
      cyc(1);
      bus(0, 0, 1, 0, got);
      check("mask_discard", got, 8'h00);

      for (int n = 0; n < 3000; n++) begin
         irq_in = ($urandom_range(0, 3) == 0) ? 8'($urandom) : irq_in;
         nmi_in = ($urandom_range(0, 4) == 0) ? ~nmi_in : nmi_in;
         cycle = ($urandom_range(0, 2) == 0);
         iack = ($urandom_range(0, 4) == 0);
         write = $urandom_range(0, 1) == 1;
         address = ($urandom_range(0, 9) < 8) ?
                   {14'h3FC0, 2'($urandom)} : 16'($urandom);
         wdata = 8'($urandom);
         cyc(1);
      end
      cycle = 0; write = 0; iack = 0;
      cyc(4);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
